// File: rtl/mmio_confreg_pkg.sv
// mmio_confreg_pkg
//   Shared constants for the memory-mapped configuration register block:
//   register byte offsets relative to BASE_ADDR and the STAT bit layout.
package mmio_confreg_pkg;

    localparam logic [31:0] OFF_SW    = 32'h0000_0000;  // debounced switches, RO
    localparam logic [31:0] OFF_LED   = 32'h0000_0004;  // LED register, RW
    localparam logic [31:0] OFF_TIMER = 32'h0000_0008;  // free-running timer, RW
    localparam logic [31:0] OFF_CMP   = 32'h0000_000C;  // timer compare, RW
    localparam logic [31:0] OFF_STAT  = 32'h0000_0010;  // status, W1C
    localparam logic [31:0] OFF_IEN   = 32'h0000_0014;  // interrupt enable, RW

    localparam int STAT_MATCH = 0;  // STAT bit: timer reached CMP

    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce
//   Brings raw asynchronous switch pins into the clk domain through a 2-flop
//   synchronizer, normalises polarity (1 = switch active), and debounces each
//   bit independently: the output bit follows the synchronized value only
//   after DEB_CYCLES consecutive cycles of disagreement.
// Ports
//   clk     in   sole clock
//   resetn  in   asynchronous active-low reset
//   sw_raw  in   SW_W raw switch pins
//   sw_deb  out  SW_W debounced, polarity-normalised switch state
module sw_debounce #(
    parameter int SW_W       = 8,
    parameter int DEB_CYCLES = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] sw_deb
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SW_W-1:0] sync1, sync2, sync_val;

    // Synchronizer flops reset to the pin level that reads as inactive,
    // so sync_val starts at 0 and agrees with the debounced state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= {SW_W{ACTIVE_LOW}};
            sync2 <= {SW_W{ACTIVE_LOW}};
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    assign sync_val = ACTIVE_LOW ? ~sync2 : sync2;

    for (genvar i = 0; i < SW_W; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          deb_q;

        // The edge that would see the DEB_CYCLES-th disagreement commits the
        // new value directly, giving 2 + DEB_CYCLES cycles pin-to-output.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt   <= '0;
                deb_q <= 1'b0;
            end else if (sync_val[i] == deb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                deb_q <= sync_val[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign sw_deb[i] = deb_q;
    end

endmodule

// File: rtl/mmio_confreg.sv
// mmio_confreg
//   Small MMIO register block: debounced switch readback, LED output
//   register, free-running 32-bit timer with compare-match status and a
//   level interrupt.
// Ports
//   clk     in   sole clock
//   resetn  in   asynchronous active-low reset
//   we      in   write strobe, one write per asserted cycle
//   addr    in   32-bit byte address (full match required)
//   wdata   in   32-bit write data
//   rdata   out  32-bit combinational read data, 0 when unmapped
//   led     out  LED_W LED pins
//   switch  in   SW_W raw switch pins
//   irq     out  level interrupt = STAT.match & IEN[0]
module mmio_confreg
    import mmio_confreg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0400,
    parameter int          LED_W          = 16,
    parameter int          SW_W           = 8,
    parameter int          DEB_CYCLES     = 4,
    parameter bit          LED_ACTIVE_LOW = 1'b1,
    parameter bit          SW_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  switch,
    output logic             irq
);

    logic [LED_W-1:0] led_reg;
    logic [31:0]      timer, cmp;
    logic             stat_match;
    logic             ien;
    logic [SW_W-1:0]  sw_deb;

    logic sel_sw, sel_led, sel_timer, sel_cmp, sel_stat, sel_ien;

    assign sel_sw    = (addr == BASE_ADDR + OFF_SW);
    assign sel_led   = (addr == BASE_ADDR + OFF_LED);
    assign sel_timer = (addr == BASE_ADDR + OFF_TIMER);
    assign sel_cmp   = (addr == BASE_ADDR + OFF_CMP);
    assign sel_stat  = (addr == BASE_ADDR + OFF_STAT);
    assign sel_ien   = (addr == BASE_ADDR + OFF_IEN);

    sw_debounce #(
        .SW_W       (SW_W),
        .DEB_CYCLES (DEB_CYCLES),
        .ACTIVE_LOW (SW_ACTIVE_LOW)
    ) u_sw_debounce (
        .clk    (clk),
        .resetn (resetn),
        .sw_raw (switch),
        .sw_deb (sw_deb)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_reg <= '0;
            cmp     <= CMP_RST;
            ien     <= 1'b0;
        end else if (we) begin
            if (sel_led) led_reg <= wdata[LED_W-1:0];
            if (sel_cmp) cmp     <= wdata;
            if (sel_ien) ien     <= wdata[0];
        end
    end

    // A load replaces the increment for that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              timer <= '0;
        else if (we && sel_timer) timer <= wdata;
        else                      timer <= timer + 32'd1;
    end

    // Compare uses the registered timer, so the flag shows one cycle after
    // equality; a set on the same edge as a W1C takes priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                    stat_match <= 1'b0;
        else if (timer == cmp)                          stat_match <= 1'b1;
        else if (we && sel_stat && wdata[STAT_MATCH])   stat_match <= 1'b0;
    end

    always_comb begin
        rdata = '0;
        if (sel_sw)         rdata = 32'(sw_deb);
        else if (sel_led)   rdata = 32'(led_reg);
        else if (sel_timer) rdata = timer;
        else if (sel_cmp)   rdata = cmp;
        else if (sel_stat)  rdata[STAT_MATCH] = stat_match;
        else if (sel_ien)   rdata[0] = ien;
    end

    assign led = LED_ACTIVE_LOW ? ~led_reg : led_reg;
    assign irq = stat_match & ien;

endmodule

// File: doc/mmio_confreg.md
MMIO_CONFREG -- requirements
Module: mmio_confreg

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0400, byte address of register 0.
REQ-002 SHALL have parameter LED_W, default 16, LED count (1..32).
REQ-003 SHALL have parameter SW_W, default 8, switch count (1..32).
REQ-004 SHALL have parameter DEB_CYCLES, default 4, debounce stability count (>=1).
REQ-005 SHALL have parameters LED_ACTIVE_LOW and SW_ACTIVE_LOW, default 1, pin polarity.
REQ-006 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-008 SHALL have port we  in  1  write strobe, one write per asserted cycle.
REQ-009 SHALL have port addr  in  32  byte address.
REQ-010 SHALL have port wdata  in  32  write data.
REQ-011 SHALL have port rdata  out  32  read data.
REQ-012 SHALL have port led  out  LED_W  LED pins.
REQ-013 SHALL have port switch  in  SW_W  raw asynchronous switch pins.
REQ-014 SHALL have port irq  out  1  level interrupt.

Function
REQ-015 Register map, offsets from BASE_ADDR, SHALL be: +0x00 SW (RO), +0x04 LED (RW), +0x08 TIMER (RW), +0x0C CMP (RW), +0x10 STAT (bit0 match, W1C), +0x14 IEN (bit0, RW).
REQ-016 A register SHALL be selected only on full 32-bit address equality; no aliasing.
REQ-017 rdata SHALL be combinational from addr, zero-extended, 0 for unmapped addresses.
REQ-018 Writes to SW or unmapped addresses SHALL be ignored.
REQ-019 Writes SHALL take effect on the clk edge where we=1; readback valid next cycle.
REQ-020 LED register SHALL store wdata[LED_W-1:0]; led = LED register, inverted when LED_ACTIVE_LOW=1.
REQ-021 Each switch bit SHALL pass a 2-flop synchronizer, then be inverted when SW_ACTIVE_LOW=1.
REQ-022 Debounced bit SHALL update to the synchronized value after DEB_CYCLES consecutive cycles of disagreement; any agreement cycle SHALL reset that bit's counter.
REQ-023 Switch change to SW readback latency SHALL be 2 + DEB_CYCLES cycles.
REQ-024 TIMER SHALL increment by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
REQ-025 A TIMER write SHALL load wdata and suppress that cycle's increment.
REQ-026 STAT.match SHALL be set on the cycle after TIMER equals CMP.
REQ-027 A W1C write with wdata[0]=1 SHALL clear STAT.match; a coincident set SHALL win.
REQ-028 irq SHALL equal STAT.match AND IEN[0], registered-state derived, no combinational path from inputs.

Reset
REQ-029 On resetn low, asynchronously: LED=0, TIMER=0, CMP=32'hFFFF_FFFF, STAT=0, IEN=0, synchronizers and debounced values = inactive level (0 after polarity), counters=0.
REQ-030 led SHALL show all-off (all 1 when LED_ACTIVE_LOW) and irq=0 during reset.
REQ-031 Reset mid-debounce SHALL discard pending counts; reset release SHALL need no extra sequencing.

Structure
REQ-032 Package mmio_confreg_pkg SHALL hold register offset constants and STAT bit index.
REQ-033 Sub-module sw_debounce (synchronizer plus per-bit counter, parameters SW_W, DEB_CYCLES) SHALL be instantiated once.
REQ-034 Counter width SHALL be $clog2(DEB_CYCLES+1).

Verification
REQ-035 Defaults: write 32'h0000_A5A5 to 0x404 -> led=16'h5A5A next cycle, read 0x404 = 32'h0000_A5A5.
REQ-036 Defaults: switch 8'hFF->8'hFE held -> read 0x400 = 32'h1 exactly 6 cycles later; 3-cycle glitch -> stays 0.
REQ-037 Write CMP=0x10, IEN=1, TIMER=0x0 -> STAT.match and irq rise when TIMER reaches 0x11 readback; W1C 0x410 with 1 -> irq=0.
REQ-038 Write TIMER=32'hFFFF_FFFE -> reads 32'hFFFF_FFFF then 0 on following cycles.
REQ-039 Match and W1C same cycle -> STAT.match remains 1; write to 0x400 or 0x418 -> no state change, read 0x418 = 0.
REQ-040 Assert resetn mid-operation with LED=0xFFFF -> led=16'hFFFF (all-off), TIMER read 0, irq=0 immediately.
